// File: rtl/axi_req_arbiter.sv
// axi_req_arbiter: two-requester round-robin front end onto a single AXI4
// master port. One single-beat transaction is in flight at a time; the
// owning requester gets a one-cycle accept pulse at grant and a one-cycle
// completion pulse (with read data and error flag) when the slave answers.
//
//   state        | meaning
//   -------------+----------------------------------------------------------
//   IDLE         | waiting for a request; grants round-robin and latches it
//   WR_ADDR_DATA | AW and W presented together, each until its handshake
//   WR_RESP      | BREADY high, waiting for the write response
//   RD_ADDR      | ARVALID high, waiting for ARREADY
//   RD_DATA      | RREADY high, absorbing beats until RLAST
//   RESP         | one-cycle RSP_VALID to the owner, then back to IDLE
module axi_req_arbiter #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ID_WIDTH   = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,

    input  logic [1:0]                      REQ_VALID,
    input  logic [1:0]                      REQ_WRITE,
    input  logic [2*AXI_ADDR_WIDTH-1:0]     REQ_ADDR,
    input  logic [2*AXI_DATA_WIDTH-1:0]     REQ_WDATA,
    input  logic [2*AXI_DATA_WIDTH/8-1:0]   REQ_WSTRB,
    output logic [1:0]                      REQ_READY,
    output logic [1:0]                      RSP_VALID,
    output logic [AXI_DATA_WIDTH-1:0]       RSP_RDATA,
    output logic                            RSP_ERR,

    output logic [AXI_ADDR_WIDTH-1:0]       M_AXI_AWADDR,
    output logic                            M_AXI_AWVALID,
    output logic [AXI_ID_WIDTH-1:0]         M_AXI_AWID,
    output logic [7:0]                      M_AXI_AWLEN,
    output logic [2:0]                      M_AXI_AWSIZE,
    output logic [1:0]                      M_AXI_AWBURST,
    input  logic                            M_AXI_AWREADY,

    output logic [AXI_DATA_WIDTH-1:0]       M_AXI_WDATA,
    output logic [AXI_DATA_WIDTH/8-1:0]     M_AXI_WSTRB,
    output logic                            M_AXI_WVALID,
    output logic                            M_AXI_WLAST,
    input  logic                            M_AXI_WREADY,

    input  logic [1:0]                      M_AXI_BRESP,
    input  logic                            M_AXI_BVALID,
    input  logic [AXI_ID_WIDTH-1:0]         M_AXI_BID,
    output logic                            M_AXI_BREADY,

    output logic [AXI_ADDR_WIDTH-1:0]       M_AXI_ARADDR,
    output logic                            M_AXI_ARVALID,
    output logic [AXI_ID_WIDTH-1:0]         M_AXI_ARID,
    output logic [7:0]                      M_AXI_ARLEN,
    output logic [2:0]                      M_AXI_ARSIZE,
    output logic [1:0]                      M_AXI_ARBURST,
    input  logic                            M_AXI_ARREADY,

    input  logic [AXI_DATA_WIDTH-1:0]       M_AXI_RDATA,
    input  logic [1:0]                      M_AXI_RRESP,
    input  logic                            M_AXI_RVALID,
    input  logic [AXI_ID_WIDTH-1:0]         M_AXI_RID,
    input  logic                            M_AXI_RLAST,
    output logic                            M_AXI_RREADY
);

    localparam int STRB_WIDTH = AXI_DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        WR_ADDR_DATA = 3'd1,
        WR_RESP      = 3'd2,
        RD_ADDR      = 3'd3,
        RD_DATA      = 3'd4,
        RESP         = 3'd5
    } state_t;

    state_t state;
    state_t state_nxt;

    // Arbitration bookkeeping; last_grant resets to 1 so requester 0 wins first.
    logic                       run;
    logic                       last_grant;
    logic                       owner;
    logic                       grant_idx;
    logic                       grant_any;
    logic [AXI_ID_WIDTH-1:0]    grant_id;

    // Latched request payload.
    logic [AXI_ADDR_WIDTH-1:0]  addr_q;
    logic [AXI_DATA_WIDTH-1:0]  wdata_q;
    logic [STRB_WIDTH-1:0]      wstrb_q;

    // Registered handshake outputs and their next values.
    logic awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
    logic awvalid_nxt, wvalid_nxt, bready_nxt, arvalid_nxt, rready_nxt;
    logic aw_done_q, w_done_q;
    logic aw_done_nxt, w_done_nxt;

    // Completion payload.
    logic                       err_q;
    logic [AXI_DATA_WIDTH-1:0]  rdata_q;

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic aw_ok, w_ok;

    assign aw_hs = awvalid_q & M_AXI_AWREADY;
    assign w_hs  = wvalid_q  & M_AXI_WREADY;
    assign b_hs  = bready_q  & M_AXI_BVALID;
    assign ar_hs = arvalid_q & M_AXI_ARREADY;
    assign r_hs  = rready_q  & M_AXI_RVALID;

    assign aw_ok = aw_done_q | aw_hs;
    assign w_ok  = w_done_q  | w_hs;

    assign grant_id = AXI_ID_WIDTH'(owner);

    // Round-robin pick: on contention the requester not granted last wins.
    always_comb begin
        grant_idx = REQ_VALID[1];
        if (REQ_VALID == 2'b11) begin
            grant_idx = ~last_grant;
        end
    end

    // run is a flop held low by reset, so no grant (and no REQ_READY) while
    // rst_n is low and during the first edge after release.
    assign grant_any = run && (state == IDLE) && (REQ_VALID != 2'b00);

    // Accept pulse to the granted requester, only in the grant cycle.
    always_comb begin
        REQ_READY = 2'b00;
        if (grant_any) begin
            REQ_READY[grant_idx] = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and next values for the registered slave-side handshakes.
    always_comb begin
        state_nxt   = state;
        awvalid_nxt = 1'b0;
        wvalid_nxt  = 1'b0;
        bready_nxt  = 1'b0;
        arvalid_nxt = 1'b0;
        rready_nxt  = 1'b0;
        aw_done_nxt = aw_done_q;
        w_done_nxt  = w_done_q;
        case (state)
            IDLE: begin
                if (grant_any) begin
                    aw_done_nxt = 1'b0;
                    w_done_nxt  = 1'b0;
                    if (REQ_WRITE[grant_idx]) begin
                        state_nxt   = WR_ADDR_DATA;
                        awvalid_nxt = 1'b1;
                        wvalid_nxt  = 1'b1;
                    end else begin
                        state_nxt   = RD_ADDR;
                        arvalid_nxt = 1'b1;
                    end
                end
            end
            WR_ADDR_DATA: begin
                aw_done_nxt = aw_ok;
                w_done_nxt  = w_ok;
                awvalid_nxt = awvalid_q & ~M_AXI_AWREADY;
                wvalid_nxt  = wvalid_q  & ~M_AXI_WREADY;
                if (aw_ok && w_ok) begin
                    state_nxt  = WR_RESP;
                    bready_nxt = 1'b1;
                end
            end
            WR_RESP: begin
                if (b_hs) begin
                    state_nxt = RESP;
                end else begin
                    bready_nxt = 1'b1;
                end
            end
            RD_ADDR: begin
                if (ar_hs) begin
                    state_nxt  = RD_DATA;
                    rready_nxt = 1'b1;
                end else begin
                    arvalid_nxt = 1'b1;
                end
            end
            RD_DATA: begin
                if (r_hs && M_AXI_RLAST) begin
                    state_nxt = RESP;
                end else begin
                    rready_nxt = 1'b1;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Handshake output registers; nothing reaches a VALID combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            awvalid_q <= awvalid_nxt;
            wvalid_q  <= wvalid_nxt;
            bready_q  <= bready_nxt;
            arvalid_q <= arvalid_nxt;
            rready_q  <= rready_nxt;
            aw_done_q <= aw_done_nxt;
            w_done_q  <= w_done_nxt;
        end
    end

    // Grant bookkeeping and request payload latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run        <= 1'b0;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
        end else begin
            run <= 1'b1;
            if (grant_any) begin
                last_grant <= grant_idx;
                owner      <= grant_idx;
                addr_q     <= grant_idx ? REQ_ADDR[2*AXI_ADDR_WIDTH-1:AXI_ADDR_WIDTH]
                                        : REQ_ADDR[AXI_ADDR_WIDTH-1:0];
                wdata_q    <= grant_idx ? REQ_WDATA[2*AXI_DATA_WIDTH-1:AXI_DATA_WIDTH]
                                        : REQ_WDATA[AXI_DATA_WIDTH-1:0];
                wstrb_q    <= grant_idx ? REQ_WSTRB[2*STRB_WIDTH-1:STRB_WIDTH]
                                        : REQ_WSTRB[STRB_WIDTH-1:0];
            end
        end
    end

    // Response capture: B status, or every R beat (the last beat's data wins).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            if ((state == WR_RESP) && b_hs) begin
                err_q <= (M_AXI_BRESP != 2'b00) || (M_AXI_BID != grant_id);
            end
            if ((state == RD_DATA) && r_hs) begin
                rdata_q <= M_AXI_RDATA;
                if (M_AXI_RLAST) begin
                    err_q <= (M_AXI_RRESP != 2'b00) || (M_AXI_RID != grant_id);
                end
            end
        end
    end

    assign RSP_VALID = (state == RESP) ? (owner ? 2'b10 : 2'b01) : 2'b00;
    assign RSP_ERR   = (state == RESP) && err_q;
    assign RSP_RDATA = rdata_q;

    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_AWID    = grant_id;
    assign M_AXI_AWLEN   = 8'd0;
    assign M_AXI_AWSIZE  = 3'd3;
    assign M_AXI_AWBURST = 2'b01;

    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = wstrb_q;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_WLAST   = 1'b1;

    assign M_AXI_BREADY  = bready_q;

    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_ARID    = grant_id;
    assign M_AXI_ARLEN   = 8'd0;
    assign M_AXI_ARSIZE  = 3'd3;
    assign M_AXI_ARBURST = 2'b01;

    assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_axi_req_arbiter.sv
// Directed bench for axi_req_arbiter: the bench plays both requesters and
// the AXI slave, and checks grants, slave-side handshakes and responses.
module tb_axi_req_arbiter;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [1:0]   REQ_VALID, REQ_WRITE, REQ_READY, RSP_VALID;
    logic [63:0]  REQ_ADDR;
    logic [127:0] REQ_WDATA;
    logic [15:0]  REQ_WSTRB;
    logic [63:0]  RSP_RDATA;
    logic         RSP_ERR;
    logic [31:0]  M_AXI_AWADDR, M_AXI_ARADDR;
    logic         M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WLAST, M_AXI_WREADY;
    logic [3:0]   M_AXI_AWID, M_AXI_ARID, M_AXI_BID, M_AXI_RID;
    logic [7:0]   M_AXI_AWLEN, M_AXI_ARLEN, M_AXI_WSTRB;
    logic [2:0]   M_AXI_AWSIZE, M_AXI_ARSIZE;
    logic [1:0]   M_AXI_AWBURST, M_AXI_ARBURST, M_AXI_BRESP, M_AXI_RRESP;
    logic [63:0]  M_AXI_WDATA, M_AXI_RDATA;
    logic         M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
    logic         M_AXI_RVALID, M_AXI_RLAST, M_AXI_RREADY;

    int n_tests = 0;
    int n_fail  = 0;
    int rsp_cnt0 = 0;
    int rsp_cnt1 = 0;

    axi_req_arbiter #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(64), .AXI_ID_WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .REQ_VALID(REQ_VALID), .REQ_WRITE(REQ_WRITE), .REQ_ADDR(REQ_ADDR),
        .REQ_WDATA(REQ_WDATA), .REQ_WSTRB(REQ_WSTRB), .REQ_READY(REQ_READY),
        .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR),
        .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWID(M_AXI_AWID),
        .M_AXI_AWLEN(M_AXI_AWLEN), .M_AXI_AWSIZE(M_AXI_AWSIZE), .M_AXI_AWBURST(M_AXI_AWBURST),
        .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WVALID(M_AXI_WVALID),
        .M_AXI_WLAST(M_AXI_WLAST), .M_AXI_WREADY(M_AXI_WREADY),
        .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BID(M_AXI_BID),
        .M_AXI_BREADY(M_AXI_BREADY),
        .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARID(M_AXI_ARID),
        .M_AXI_ARLEN(M_AXI_ARLEN), .M_AXI_ARSIZE(M_AXI_ARSIZE), .M_AXI_ARBURST(M_AXI_ARBURST),
        .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RVALID(M_AXI_RVALID),
        .M_AXI_RID(M_AXI_RID), .M_AXI_RLAST(M_AXI_RLAST), .M_AXI_RREADY(M_AXI_RREADY)
    );

    always #5 clk = ~clk;

    // Completion pulse counters per requester.
    always @(negedge clk) begin
        if (RSP_VALID[0]) rsp_cnt0++;
        if (RSP_VALID[1]) rsp_cnt1++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, want finish before time limit");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_grant(output logic [1:0] g);
        g = 2'b00;
        for (int i = 0; i < 30; i++) begin
            #1;
            if (REQ_READY != 2'b00) begin
                g = REQ_READY;
                break;
            end
            tick();
        end
    endtask

    task automatic wait_rsp(output logic [1:0] v, output logic e, output logic [63:0] d);
        v = 2'b00; e = 1'b0; d = '0;
        for (int i = 0; i < 30; i++) begin
            if (RSP_VALID != 2'b00) begin
                v = RSP_VALID; e = RSP_ERR; d = RSP_RDATA;
                break;
            end
            tick();
        end
    endtask

    // Raise one request, wait for its accept pulse, then drop it and scramble
    // the payload so that only the latched copy can reach the slave.
    task automatic issue(input int who, input logic wr, input logic [31:0] addr,
                         input logic [63:0] wdata, output logic [1:0] g);
        REQ_WRITE[who] = wr;
        REQ_ADDR[who*32 +: 32] = addr;
        REQ_WDATA[who*64 +: 64] = wdata;
        REQ_VALID[who] = 1'b1;
        wait_grant(g);
        tick();
        REQ_VALID[who] = 1'b0;
        REQ_ADDR[who*32 +: 32] = ~addr;
        REQ_WDATA[who*64 +: 64] = ~wdata;
    endtask

    // Write slave: AWREADY after aw_dly cycles of AWVALID, WREADY immediate,
    // then one B beat.
    task automatic slave_write(input int aw_dly, input logic [1:0] bresp, input logic bad_id,
                               output int aw_hi, output int w_hi, output logic early_b,
                               output logic [31:0] addr, output logic [63:0] data,
                               output logic [3:0] id);
        int t;
        logic aw_ok, w_ok;
        t = 0;
        while (!M_AXI_AWVALID && t < 20) begin tick(); t++; end
        chk("aw_seen", M_AXI_AWVALID, 1'b1);
        addr = M_AXI_AWADDR; data = M_AXI_WDATA; id = M_AXI_AWID;
        aw_hi = 0; w_hi = 0; aw_ok = 1'b0; w_ok = 1'b0; early_b = 1'b0;
        t = 0;
        while (!(aw_ok && w_ok) && t < 20) begin
            if (M_AXI_BREADY) early_b = 1'b1;
            if (M_AXI_AWVALID) aw_hi++;
            if (M_AXI_WVALID) w_hi++;
            M_AXI_AWREADY = M_AXI_AWVALID && (aw_hi > aw_dly);
            M_AXI_WREADY  = M_AXI_WVALID;
            if (M_AXI_AWVALID && M_AXI_AWREADY) aw_ok = 1'b1;
            if (M_AXI_WVALID && M_AXI_WREADY) w_ok = 1'b1;
            tick(); t++;
        end
        M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0;
        chk("aw_drop", M_AXI_AWVALID, 1'b0);
        chk("w_drop", M_AXI_WVALID, 1'b0);
        t = 0;
        while (!M_AXI_BREADY && t < 20) begin tick(); t++; end
        M_AXI_BVALID = 1'b1; M_AXI_BRESP = bresp;
        M_AXI_BID = bad_id ? (id ^ 4'h1) : id;
        tick();
        M_AXI_BVALID = 1'b0; M_AXI_BRESP = 2'b00;
    endtask

    // Read slave: immediate ARREADY, then 'beats' R beats (last carries d_last).
    task automatic slave_read(input int beats, input logic [63:0] d_first, input logic [63:0] d_last,
                              input logic [1:0] rresp, input logic bad_id,
                              output logic [3:0] id, output logic [31:0] addr);
        int t;
        t = 0;
        while (!M_AXI_ARVALID && t < 20) begin tick(); t++; end
        chk("ar_seen", M_AXI_ARVALID, 1'b1);
        id = M_AXI_ARID; addr = M_AXI_ARADDR;
        M_AXI_ARREADY = 1'b1;
        tick();
        M_AXI_ARREADY = 1'b0;
        chk("ar_drop", M_AXI_ARVALID, 1'b0);
        t = 0;
        while (!M_AXI_RREADY && t < 20) begin tick(); t++; end
        for (int b = 0; b < beats; b++) begin
            M_AXI_RVALID = 1'b1;
            M_AXI_RDATA  = (b == beats - 1) ? d_last : d_first;
            M_AXI_RLAST  = (b == beats - 1);
            M_AXI_RRESP  = rresp;
            M_AXI_RID    = bad_id ? (id ^ 4'h1) : id;
            tick();
        end
        M_AXI_RVALID = 1'b0; M_AXI_RLAST = 1'b0; M_AXI_RRESP = 2'b00;
    endtask

    initial begin
        logic [1:0]  g, v;
        logic        e, eb;
        logic [63:0] d, wd;
        logic [31:0] a;
        logic [3:0]  id;
        int          awh, wh, c0, c1;

        REQ_VALID = 2'b11; REQ_WRITE = 2'b00; REQ_ADDR = '0; REQ_WDATA = '0; REQ_WSTRB = '1;
        M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_BVALID = 0; M_AXI_BRESP = 0; M_AXI_BID = 0;
        M_AXI_ARREADY = 0; M_AXI_RVALID = 0; M_AXI_RDATA = 0; M_AXI_RRESP = 0;
        M_AXI_RID = 0; M_AXI_RLAST = 0;

        // Reset state, with both requests pending.
        repeat (2) tick();
        #1;
        chk("rst_req_ready", REQ_READY, 2'b00);
        chk("rst_awvalid", M_AXI_AWVALID, 1'b0);
        chk("rst_wvalid", M_AXI_WVALID, 1'b0);
        chk("rst_arvalid", M_AXI_ARVALID, 1'b0);
        chk("rst_bready", M_AXI_BREADY, 1'b0);
        chk("rst_rready", M_AXI_RREADY, 1'b0);
        chk("rst_rsp_valid", RSP_VALID, 2'b00);
        chk("rst_rsp_err", RSP_ERR, 1'b0);
        chk("rst_rsp_rdata", RSP_RDATA, 64'h0);
        chk("awlen", M_AXI_AWLEN, 8'd0);
        chk("arsize", M_AXI_ARSIZE, 3'd3);
        chk("awburst", M_AXI_AWBURST, 2'b01);
        chk("wlast", M_AXI_WLAST, 1'b1);
        REQ_VALID = 2'b00;
        tick(); #2 rst_n = 1'b1;
        tick();

        // Both requesters writing back-to-back: grants 0,1,0.
        REQ_ADDR  = {32'h0000_2000, 32'h0000_1000};
        REQ_WDATA = {64'hBBBB_0001_BBBB_0001, 64'hAAAA_0000_AAAA_0000};
        REQ_WRITE = 2'b11; REQ_VALID = 2'b11;
        c0 = rsp_cnt0; c1 = rsp_cnt1;
        for (int k = 0; k < 3; k++) begin
            wait_grant(g);
            chk($sformatf("rr_grant%0d", k), g, (k == 1) ? 2'b10 : 2'b01);
            tick();
            if (k == 2) REQ_VALID = 2'b00;
            #1 chk("rr_busy_ready", REQ_READY, 2'b00);
            slave_write(0, 2'b00, 1'b0, awh, wh, eb, a, wd, id);
            chk("rr_awid", id, (k == 1) ? 4'd1 : 4'd0);
            chk("rr_awaddr", a, (k == 1) ? 32'h0000_2000 : 32'h0000_1000);
            chk("rr_wdata", wd, (k == 1) ? 64'hBBBB_0001_BBBB_0001 : 64'hAAAA_0000_AAAA_0000);
            wait_rsp(v, e, d);
            chk("rr_rsp_valid", v, (k == 1) ? 2'b10 : 2'b01);
            chk("rr_rsp_err", e, 1'b0);
        end
        tick(); #1;
        chk("rr_cnt0", rsp_cnt0 - c0, 2);
        chk("rr_cnt1", rsp_cnt1 - c1, 1);
        tick();

        // Single read by requester 1.
        issue(1, 1'b0, 32'h0000_1000, 64'h0, g);
        chk("rd1_grant", g, 2'b10);
        slave_read(1, 64'h0, 64'hDEAD_BEEF_0123_4567, 2'b00, 1'b0, id, a);
        chk("rd1_arid", id, 4'd1);
        chk("rd1_araddr", a, 32'h0000_1000);
        wait_rsp(v, e, d);
        chk("rd1_rsp_valid", v, 2'b10);
        chk("rd1_rdata", d, 64'hDEAD_BEEF_0123_4567);
        chk("rd1_err", e, 1'b0);
        tick();

        // SLVERR on B.
        issue(0, 1'b1, 32'h0000_3000, 64'hA5A5_A5A5_5A5A_5A5A, g);
        chk("slverr_grant", g, 2'b01);
        slave_write(0, 2'b10, 1'b0, awh, wh, eb, a, wd, id);
        wait_rsp(v, e, d);
        chk("slverr_rsp_valid", v, 2'b01);
        chk("slverr_err", e, 1'b1);
        tick();

        // BID differing from AWID.
        issue(1, 1'b1, 32'h0000_4000, 64'h1234_5678_9ABC_DEF0, g);
        chk("bid_grant", g, 2'b10);
        slave_write(0, 2'b00, 1'b1, awh, wh, eb, a, wd, id);
        chk("bid_awid", id, 4'd1);
        wait_rsp(v, e, d);
        chk("bid_rsp_valid", v, 2'b10);
        chk("bid_err", e, 1'b1);
        tick();

        // RID differing from ARID.
        issue(0, 1'b0, 32'h0000_4800, 64'h0, g);
        slave_read(1, 64'h0, 64'h0000_0000_CAFE_F00D, 2'b00, 1'b1, id, a);
        wait_rsp(v, e, d);
        chk("rid_rsp_valid", v, 2'b01);
        chk("rid_err", e, 1'b1);
        tick();

        // AWREADY three cycles late, WREADY immediate.
        issue(0, 1'b1, 32'h0000_5000, 64'h0123_4567_89AB_CDEF, g);
        slave_write(3, 2'b00, 1'b0, awh, wh, eb, a, wd, id);
        chk("dly_aw_hold", awh, 4);
        chk("dly_w_hold", wh, 1);
        chk("dly_early_bready", eb, 1'b0);
        chk("dly_awaddr", a, 32'h0000_5000);
        wait_rsp(v, e, d);
        chk("dly_rsp_valid", v, 2'b01);
        chk("dly_err", e, 1'b0);
        tick();

        // Two-beat read: one completion carrying the second beat.
        issue(0, 1'b0, 32'h0000_6000, 64'h0, g);
        c0 = rsp_cnt0;
        slave_read(2, 64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, 2'b00, 1'b0, id, a);
        wait_rsp(v, e, d);
        chk("beat2_rsp_valid", v, 2'b01);
        chk("beat2_rdata", d, 64'h5555_6666_7777_8888);
        chk("beat2_err", e, 1'b0);
        tick(); #1;
        chk("beat2_cnt", rsp_cnt0 - c0, 1);
        tick();

        // Reset in RD_DATA after a requester-0 grant.
        issue(0, 1'b0, 32'h0000_7000, 64'h0, g);
        M_AXI_ARREADY = 1'b1;
        tick();
        M_AXI_ARREADY = 1'b0;
        chk("mid_rready_pre", M_AXI_RREADY, 1'b1);
        REQ_WRITE = 2'b11; REQ_VALID = 2'b11;
        c0 = rsp_cnt0; c1 = rsp_cnt1;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rready", M_AXI_RREADY, 1'b0);
        chk("mid_arvalid", M_AXI_ARVALID, 1'b0);
        chk("mid_awvalid", M_AXI_AWVALID, 1'b0);
        chk("mid_wvalid", M_AXI_WVALID, 1'b0);
        chk("mid_bready", M_AXI_BREADY, 1'b0);
        chk("mid_req_ready", REQ_READY, 2'b00);
        chk("mid_rsp_valid", RSP_VALID, 2'b00);
        chk("mid_rsp_err", RSP_ERR, 1'b0);
        chk("mid_rsp_rdata", RSP_RDATA, 64'h0);
        tick(); #2 rst_n = 1'b1;
        wait_grant(g);
        chk("mid_next_grant", g, 2'b01);
        tick();
        REQ_VALID = 2'b00;
        slave_write(0, 2'b00, 1'b0, awh, wh, eb, a, wd, id);
        chk("mid_next_awid", id, 4'd0);
        wait_rsp(v, e, d);
        chk("mid_next_rsp", v, 2'b01);
        tick(); #1;
        chk("mid_cnt0", rsp_cnt0 - c0, 1);
        chk("mid_cnt1", rsp_cnt1 - c1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
